// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 slot demultiplexer: channel count,
// channel select type and the per-slot occupancy state encoding.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: data register, EMPTY/FULL occupancy FSM and a
// wrapping accept counter with synchronous clear.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          take,
    input  logic          clr,
    input  logic [W-1:0]  data,
    output logic          valid,
    output logic [W-1:0]  q,
    output logic [CW-1:0] cnt
);

    slot_state_t state_q;
    slot_state_t state_d;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load while full refills in place, so a simultaneous take never empties
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load)          state_d = SLOT_FULL;
            SLOT_FULL:  if (take && !load) state_d = SLOT_EMPTY;
            default:                       state_d = SLOT_EMPTY;
        endcase
    end

    assign valid = (state_q == SLOT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/demux14_slot.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into the slot
// named by in_sel and holds it until that channel's consumer takes it.
module demux14_slot
    import demux_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  ch_sel_t              in_sel,
    input  logic [W-1:0]         in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*W-1:0]  out_data,
    input  logic                 cnt_clr,
    output logic [NUM_CH*CW-1:0] acc_cnt
);

    logic [NUM_CH-1:0] sel_dec;
    logic              accept;

    always_comb begin
        sel_dec         = '0;
        sel_dec[in_sel] = 1'b1;
    end

    // Selected slot can take a word if empty or draining this same cycle
    assign in_ready = en & (~out_valid[in_sel] | out_ready[in_sel]);
    assign accept   = in_valid & in_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(
            .W  (W),
            .CW (CW)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept & sel_dec[g]),
            .take  (out_ready[g]),
            .clr   (cnt_clr),
            .data  (in_data),
            .valid (out_valid[g]),
            .q     (out_data[g*W +: W]),
            .cnt   (acc_cnt[g*CW +: CW])
        );
    end

endmodule

// File: doc/demux14_slot.md
# demux14_slot

Registered 1-to-4 demultiplexer with enable and per-channel one-entry holding slots, the dispatch counterpart of our 4:1 enabled select path. It accepts one word per cycle from a single valid/ready source, steers it to the output channel named by `in_sel`, and holds it there until that channel's consumer takes it. Per-channel accept counters support bring-up and debug. It sits between a shared producer and four independent consumers.

## Interface
Parameters:
- `W`, default 8, data width in bits.
- `CW`, default 8, width of each per-channel accept counter.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `en`, input, 1 bit: enable; gates input acceptance only.
- `in_valid`, input, 1 bit: source word present.
- `in_ready`, output, 1 bit: block accepts the word this cycle.
- `in_sel`, input, 2 bits: destination channel, 0–3.
- `in_data`, input, W bits: payload.
- `out_valid`, output, 4 bits: bit k means slot k holds a word.
- `out_ready`, input, 4 bits: bit k means consumer k takes slot k this cycle.
- `out_data`, output, 4×W bits: channel k occupies bits [k·W +: W].
- `cnt_clr`, input, 1 bit: synchronous clear of all accept counters.
- `acc_cnt`, output, 4×CW bits: per-channel accepted-word counters, channel k at [k·CW +: CW].

## Operation
- Transfer on input: `in_valid & in_ready` at a rising edge.
- Transfer on output k: `out_valid[k] & out_ready[k]` at a rising edge.
- `in_ready = en & (~out_valid[in_sel] | out_ready[in_sel])`.
  - This is combinational from `en`, `in_sel`, `out_valid` and `out_ready`.
  - The source must hold `in_sel` and `in_data` stable while `in_valid` is high and `in_ready` is low.
- Slot k has two states, EMPTY and FULL.
  - EMPTY → FULL on an input transfer with `in_sel == k`.
  - FULL → EMPTY on an output transfer k with no simultaneous input transfer to k.
  - FULL → FULL with new data when an output transfer k and an input transfer to k occur in the same cycle. `out_valid[k]` stays 1 and `out_data` takes the new word.
- Only the selected slot loads. The other slots keep their data and continue draining independently.
- `out_data[k]` is only meaningful while `out_valid[k]` is 1. It holds its last value after the slot empties.
- `en` low:
  - `in_ready` is 0 and nothing is accepted.
  - Full slots still drain normally.
- Counters:
  - `acc_cnt[k]` increments by 1 on each input transfer to channel k.
  - Counters wrap modulo 2^CW; 255 → 0 at the default width.
  - `cnt_clr` has priority: it sets all counters to 0 in that cycle, even if a transfer occurs. The transfer itself still completes.

## Timing
- Reset values (asynchronous, while `rst_n` is low):
  - `out_valid` = 0 and all slots EMPTY.
  - `out_data` = 0.
  - `acc_cnt` = 0.
  - `in_ready` therefore equals `en`.
- Latency: a word accepted at edge N appears with `out_valid[k] = 1` after edge N, one cycle.
- Throughput: one word per cycle, including back-to-back words to the same channel whose consumer holds `out_ready[k] = 1`.
- Reset asserted mid-operation discards held words immediately. No partial transfer survives reset.
- Reset deassertion is synchronized externally. After release, the first accept can occur on the first rising edge.

## Structure
- Shared package `demux_pkg`:
  - constant `NUM_CH = 4`;
  - typedef `ch_sel_t` (2 bits).
- Sub-module `demux_slot`, instantiated four times. It holds one W-bit register, a valid flag and a CW-bit counter. Its inputs are load, take, clr and data.
- The top level decodes `in_sel`, forms `in_ready`, and concatenates the slot outputs.

## Test plan
- Reset with `en = 1`, then send `in_sel = 2`, `in_data = 0xA5`:
  - before the edge, `out_valid = 0000` and `in_ready = 1`;
  - after one cycle, `out_valid = 0100` and `out_data[2] = 0xA5`;
  - `acc_cnt[2] = 1`.
- Fill slot 1 with 0x11 while `out_ready[1] = 0`, then present 0x22 to channel 1:
  - `in_ready = 0` and slot 1 stays 0x11;
  - raise `out_ready[1]` and 0x22 is accepted in the same cycle;
  - `out_valid[1]` stays 1, `out_data[1] = 0x22`, and no bubble appears.
- With slot 0 full and blocked, send 0x33 to channel 3: it is accepted immediately and slot 0 is unchanged.
- With `en = 0`, `in_valid = 1` for 5 cycles and `out_ready = 1111`:
  - `in_ready = 0` throughout and counters do not change;
  - a previously full slot drains on its first cycle.
- Stream 257 words to channel 0 with `out_ready[0] = 1`: `acc_cnt[0] = 1` (wrapped). Then assert `cnt_clr` together with one more accept: counter = 0 and the word is delivered.
- Drop `rst_n` for 1 cycle while slots 0–3 are all full: `out_valid = 0000` immediately, and counters and data are 0.
